radix_smcu_pipe: RTL

//   Pipelined, parametrised state-metric compare unit for the Radix 2/4/8 SISO turbo decoder.
//   Per accepted sample: alpha_in + gamma_k (saturated) -> min over 2/4/8 branches (per sel).

---
 rtl/radix_smcu_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/radix_smcu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// radix_smcu_pipe : 4-stage add/saturate/min-tree state-metric compare unit
//                   for the radix 2/4/8 SISO decoder, with optional normalisation.
// Revision 1.0
// ----------------------------------------------------------------------------
module radix_smcu_pipe #(
  parameter int W        = 8,
  parameter bit NORM_EN  = 1'b1,
  parameter int NORM_THR = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     sel,
  input  logic [W-1:0]   alpha_in,
  input  logic [8*W-1:0] gamma_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   alpha_out,
  output logic [2:0]     out_idx,
  output logic           out_norm
);

  localparam logic signed [W-1:0] c_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] c_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] c_THR = NORM_THR[W-1:0];

  // True when candidate a (lower index) beats b; masked entries only win
  // against other masked entries, and ties go to the lower index.
  function automatic logic pick_a(input logic signed [W-1:0] a, input logic am,
                                  input logic signed [W-1:0] b, input logic bm);
    return bm ? 1'b1 : (!am && (a <= b));
  endfunction

  logic w_stall;
  logic [7:0] w_msk;
  logic signed [W-1:0] w_s1_val [8];

  logic                r_v1, r_v2, r_v3, r_v4;
  logic signed [W-1:0] r_s1_val [8];
  logic [7:0]          r_s1_msk;
  logic signed [W-1:0] r_s2_val [4];
  logic [2:0]          r_s2_idx [4];
  logic [3:0]          r_s2_msk;
  logic signed [W-1:0] r_s3_val [2];
  logic [2:0]          r_s3_idx [2];
  logic [1:0]          r_s3_msk;
  logic [W-1:0]        r_alpha_out;
  logic [2:0]          r_out_idx;
  logic                r_out_norm;

  assign w_stall   = r_v4 && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_v4;
  assign alpha_out = r_alpha_out;
  assign out_idx   = r_out_idx;
  assign out_norm  = r_out_norm;

  assign w_msk = (sel == 2'b10) ? 8'h00 : (sel == 2'b00) ? 8'hF0 : 8'hFC;

  for (genvar k = 0; k < 8; k++) begin : g_s1
    logic signed [W:0] w_sum;
    assign w_sum = {alpha_in[W-1], alpha_in} + {gamma_in[k*W+W-1], gamma_in[k*W +: W]};
    assign w_s1_val[k] = w_msk[k] ? c_MAX :
                         (w_sum[W] != w_sum[W-1]) ? (w_sum[W] ? c_MIN : c_MAX) :
                         w_sum[W-1:0];
  end

  logic signed [W-1:0] w_s2_val [4];
  logic [2:0]          w_s2_idx [4];
  logic [3:0]          w_s2_msk;

  for (genvar j = 0; j < 4; j++) begin : g_s2
    logic w_p;
    assign w_p = pick_a(r_s1_val[2*j], r_s1_msk[2*j], r_s1_val[2*j+1], r_s1_msk[2*j+1]);
    assign w_s2_val[j] = w_p ? r_s1_val[2*j] : r_s1_val[2*j+1];
    assign w_s2_msk[j] = w_p ? r_s1_msk[2*j] : r_s1_msk[2*j+1];
    assign w_s2_idx[j] = w_p ? 3'(2*j) : 3'(2*j+1);
  end

  logic signed [W-1:0] w_s3_val [2];
  logic [2:0]          w_s3_idx [2];
  logic [1:0]          w_s3_msk;

  for (genvar j = 0; j < 2; j++) begin : g_s3
    logic w_p;
    assign w_p = pick_a(r_s2_val[2*j], r_s2_msk[2*j], r_s2_val[2*j+1], r_s2_msk[2*j+1]);
    assign w_s3_val[j] = w_p ? r_s2_val[2*j] : r_s2_val[2*j+1];
    assign w_s3_msk[j] = w_p ? r_s2_msk[2*j] : r_s2_msk[2*j+1];
    assign w_s3_idx[j] = w_p ? r_s2_idx[2*j] : r_s2_idx[2*j+1];
  end

  logic                w_p4;
  logic signed [W-1:0] w_min;
  logic [2:0]          w_min_idx;
  logic signed [W-1:0] w_fin;
  logic                w_norm;

  assign w_p4      = pick_a(r_s3_val[0], r_s3_msk[0], r_s3_val[1], r_s3_msk[1]);
  assign w_min     = w_p4 ? r_s3_val[0] : r_s3_val[1];
  assign w_min_idx = w_p4 ? r_s3_idx[0] : r_s3_idx[1];

  if (NORM_EN) begin : g_norm
    assign w_norm = (w_min >= c_THR);
    assign w_fin  = w_norm ? (w_min - c_THR) : w_min;
  end else begin : g_no_norm
    assign w_norm = 1'b0;
    assign w_fin  = w_min;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_v3        <= 1'b0;
      r_v4        <= 1'b0;
      r_s1_msk    <= '0;
      r_s2_msk    <= '0;
      r_s3_msk    <= '0;
      r_alpha_out <= '0;
      r_out_idx   <= '0;
      r_out_norm  <= 1'b0;
      for (int i = 0; i < 8; i++) r_s1_val[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        r_s2_val[i] <= '0;
        r_s2_idx[i] <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        r_s3_val[i] <= '0;
        r_s3_idx[i] <= '0;
      end
    end else if (!w_stall) begin
      r_v1        <= in_valid;
      r_v2        <= r_v1;
      r_v3        <= r_v2;
      r_v4        <= r_v3;
      r_s1_val    <= w_s1_val;
      r_s1_msk    <= w_msk;
      r_s2_val    <= w_s2_val;
      r_s2_idx    <= w_s2_idx;
      r_s2_msk    <= w_s2_msk;
      r_s3_val    <= w_s3_val;
      r_s3_idx    <= w_s3_idx;
      r_s3_msk    <= w_s3_msk;
      r_alpha_out <= w_fin;
      r_out_idx   <= w_min_idx;
      r_out_norm  <= w_norm;
    end
  end

endmodule
`default_nettype wire
